// File: rtl/demux_mux_pkg.sv
// demux_mux_pkg: lane select type and helpers shared by the ping-pong dispatcher/collector
package demux_mux_pkg;
   localparam int LANES = 2;
   typedef logic lane_sel_t;
   function automatic lane_sel_t next_sel(lane_sel_t s);
      return ~s;
   endfunction
   function automatic logic [LANES-1:0] sel_mask(lane_sel_t s);
      return LANES'(1) << s;
   endfunction
endpackage

// File: rtl/demux_to_mux_2_if.sv
// demux_to_mux_2_if: input, lane dispatch, lane return and output streams of the dispatcher
interface demux_to_mux_2_if #(parameter int WIDTH = 2, parameter int MAX_OUT = 8);
   import demux_mux_pkg::*;
   localparam int CW = $clog2(MAX_OUT + 1);
   logic                              in_valid;
   logic                              in_ready;
   logic [WIDTH-1:0]                  in_data;
   logic [LANES-1:0]                  lane_valid;
   logic [LANES-1:0]                  lane_ready;
   logic [LANES-1:0][WIDTH-1:0]       lane_data;
   logic [LANES-1:0]                  ret_valid;
   logic [LANES-1:0]                  ret_ready;
   logic [LANES-1:0][WIDTH-1:0]       ret_data;
   logic                              out_valid;
   logic                              out_ready;
   logic [WIDTH-1:0]                  out_data;
   logic [CW-1:0]                     outstanding;
   modport master (
      output in_valid, in_data, lane_ready, ret_valid, ret_data, out_ready,
      input  in_ready, lane_valid, lane_data, ret_ready, out_valid, out_data, outstanding
   );
   modport slave (
      input  in_valid, in_data, lane_ready, ret_valid, ret_data, out_ready,
      output in_ready, lane_valid, lane_data, ret_ready, out_valid, out_data, outstanding
   );
endinterface

// File: rtl/out_stage_reg.sv
// out_stage_reg: single-entry valid/ready output register that loads whenever it is empty or being drained
module out_stage_reg #(parameter int WIDTH = 2) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             take,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   assign take = reset_n && (!out_valid || out_ready);
   // load a new beat when room is available; otherwise hold data, dropping valid once consumed
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (take) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end
endmodule

// File: rtl/demux_to_mux_2.sv
// demux_to_mux_2: order-preserving ping-pong dispatch onto two lanes and in-order collection of their results
module demux_to_mux_2
   import demux_mux_pkg::*;
#(
   parameter int ID      = 1,
   parameter int WIDTH   = 2,
   parameter int MAX_OUT = 8
) (
   input logic               clock,
   input logic               reset_n,
   demux_to_mux_2_if.slave   bus
);
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
   lane_sel_t        wr_sel;
   lane_sel_t        rd_sel;
   logic [CW-1:0]    cnt;
   logic             credit;
   logic             disp;
   logic             take;
   logic             ret_fire;
   logic             sel_valid;
   logic [WIDTH-1:0] sel_data;
   assign credit         = reset_n && (cnt < MAX_CNT);
   assign bus.lane_valid = (bus.in_valid && credit) ? sel_mask(wr_sel) : '0;
   assign bus.in_ready   = bus.lane_ready[wr_sel] && credit;
   assign bus.lane_data  = {LANES{bus.in_data}};
   assign disp           = bus.in_valid && bus.in_ready;
   assign bus.ret_ready  = take ? sel_mask(rd_sel) : '0;
   assign sel_valid      = bus.ret_valid[rd_sel];
   assign sel_data       = bus.ret_data[rd_sel];
   assign ret_fire       = sel_valid && take;
   assign bus.outstanding = cnt;
   out_stage_reg #(.WIDTH(WIDTH)) u_out (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (sel_valid),
      .in_data   (sel_data),
      .take      (take),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (bus.out_data)
   );
   // alternate write/read lanes on each transfer and track beats in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_sel <= '0;
         rd_sel <= '0;
         cnt    <= '0;
      end else begin
         if (disp) wr_sel <= next_sel(wr_sel);
         if (ret_fire) rd_sel <= next_sel(rd_sel);
         if (disp != ret_fire) cnt <= disp ? cnt + CW'(1) : cnt - CW'(1);
      end
   end
   // a lane may only return a beat that was dispatched to it
   a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n) ret_fire |-> cnt != '0)
      else $error("demux_to_mux_2 #%0d: return accepted with nothing outstanding", ID);
endmodule
